joust2_dl_router: RTL and testbench
===================================

# joust2_dl_router

Sits between the HPS download port and the `williams2` core in the Joust 2 top level. It routes the byte stream of a ROM download to four ROM regions, buffering each byte in a small FIFO so a busy target can stall the download via `ioctl_wait`. It also keeps a byte count and an 8-bit additive checksum, and pulses `load_done` once the last byte has been delivered.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `INDEX`, 0: the `ioctl_index` value this router accepts.

- `clk_sys`  in  1  system clock, 12 MHz.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `ioctl_download`  in  1  high for the whole download.
- `ioctl_index`  in  16  download index.
- `ioctl_wr`  in  1  one-cycle byte strobe.
- `ioctl_addr`  in  25  byte address.
- `ioctl_dout`  in  8  byte data.
- `ioctl_wait`  out  1  stall request to the HPS.
- `rom_valid`  out  1  a byte is offered to the core.
- `rom_ready`  in  1  the core accepts the offered byte.
- `rom_region`  out  2  target region: 0 main/bank, 1 sound, 2 graphics, 3 misc.
- `rom_addr`  out  18  byte offset inside the region.
- `rom_data`  out  8  byte.
- `byte_count`  out  19  bytes accepted into the FIFO during this download.
- `checksum`  out  8  sum mod 256 of the accepted bytes.
- `addr_overflow`  out  1  sticky; a byte with an address of 0x40000 or above was seen.
- `load_done`  out  1  one-cycle pulse when the download is complete.

## Operation
- Region map on `ioctl_addr[17:0]`:
  - 0x00000–0x1FFFF → region 0, offset `addr[16:0]`.
  - 0x20000–0x2FFFF → region 1, offset `addr[15:0]`.
  - 0x30000–0x37FFF → region 2, offset `addr[14:0]`.
  - 0x38000–0x3FFFF → region 3, offset `addr[14:0]`.
  - Offsets are zero-extended to 18 bits.
- Any address ≥ 0x40000 sets `addr_overflow` and the byte is dropped: not counted, not summed, not queued.
- Accept condition: `ioctl_wr && ioctl_download && ioctl_index==INDEX` and state is LOAD.
  - An accepted, in-range byte is pushed as {region, offset, data}.
  - On push, `byte_count` increments and `checksum` adds `ioctl_dout` (mod 256).
- A write arriving while the FIFO is full is a protocol error. It is dropped and sets `addr_overflow`.
- FIFO handshake: a pop occurs when `rom_valid && rom_ready`. `rom_*` present the FIFO head and stay stable while `rom_valid && !rom_ready`.
- State machine:
  - IDLE → LOAD on the rising edge of `ioctl_download` with a matching index. On this transition `byte_count`, `checksum` and `addr_overflow` clear.
  - LOAD → DRAIN when `ioctl_download` falls.
  - DRAIN → DONE when the FIFO is empty.
  - DONE → IDLE on the next cycle, pulsing `load_done`.
- A new download rising edge in DRAIN or DONE is ignored until IDLE is reached. `ioctl_wait` stays high in DRAIN.
- `ioctl_wait = (count >= DEPTH-1) || state==DRAIN`.

## Timing
- Reset values: `ioctl_wait`=0, `rom_valid`=0, `rom_region`=0, `rom_addr`=0, `rom_data`=0, `byte_count`=0, `checksum`=0, `addr_overflow`=0, `load_done`=0. State is IDLE and the FIFO is empty.
- Latency: a byte accepted in cycle N appears on `rom_*` with `rom_valid`=1 in cycle N+1 (registered push, first-word fall-through).
- Simultaneous push and pop: count is unchanged and both pointers advance, including when the FIFO is full.
- Pointers are `$clog2(DEPTH)` bits wide and wrap naturally. Count is `$clog2(DEPTH)+1` bits.
- `byte_count` saturates at 0x7FFFF. `checksum` wraps.
- `load_done` is asserted exactly one cycle after the final pop.
- Asserting `reset_n` low mid-download empties the FIFO at once and returns to IDLE. No `load_done` is generated.

## Structure
- Shared package `joust2_pkg` holds:
  - region enum `rom_region_t` (MAIN, SOUND, GFX, MISC);
  - region base/limit constants;
  - FSM state typedef `dl_state_t`.
- One sub-module, `dl_fifo`: a parameterised synchronous FIFO, 28 bits wide, with push/pop/full/empty/count.
- The top level holds the decoder, counters and FSM.

## Test plan
- Single bytes at 0x00005, 0x20010, 0x30003 and 0x38007 with `rom_ready`=1 → regions 0, 1, 2, 3 at offsets 0x00005, 0x00010, 0x00003, 0x00007, each one cycle after its write.
- 256 bytes of value 0x01 followed by download end → `byte_count`=256, `checksum`=0x00, one `load_done` pulse after the FIFO drains.
- Hold `rom_ready`=0 while 3 writes arrive (`DEPTH`=4) → `ioctl_wait`=1 after the third byte. Release → bytes delivered in order 0,1,2 and `ioctl_wait` falls.
- Write to 0x40000 with data 0xAA → `addr_overflow`=1, no `rom_valid`, count and checksum unchanged.
- Write with `ioctl_index`=1 → ignored entirely.
- `reset_n` pulsed low while the FIFO holds 2 bytes → `rom_valid`=0 immediately and no `load_done` afterwards.

Source files
------------

// File: rtl/joust2_pkg.sv
// Shared types and constants for the Joust 2 ROM download path.
package joust2_pkg;

  typedef enum logic [1:0] {
    RGN_MAIN  = 2'd0,
    RGN_SOUND = 2'd1,
    RGN_GFX   = 2'd2,
    RGN_MISC  = 2'd3
  } rom_region_t;

  // Region bases on the download byte address; each base is the previous region's limit.
  localparam logic [24:0] SOUND_BASE = 25'h20000;
  localparam logic [24:0] GFX_BASE   = 25'h30000;
  localparam logic [24:0] MISC_BASE  = 25'h38000;
  localparam logic [24:0] ROM_LIMIT  = 25'h40000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } dl_state_t;

  typedef struct packed {
    rom_region_t region;
    logic [17:0] offset;
    logic [7:0]  data;
  } rom_entry_t;

  localparam int unsigned ENTRY_W = $bits(rom_entry_t);

  // Caller guarantees addr < ROM_LIMIT.
  function automatic rom_entry_t decode_entry(input logic [24:0] addr, input logic [7:0] data);
    rom_entry_t e;
    e.data = data;
    if (addr < SOUND_BASE) begin
      e.region = RGN_MAIN;
      e.offset = {1'b0, addr[16:0]};
    end else if (addr < GFX_BASE) begin
      e.region = RGN_SOUND;
      e.offset = {2'b00, addr[15:0]};
    end else if (addr < MISC_BASE) begin
      e.region = RGN_GFX;
      e.offset = {3'b000, addr[14:0]};
    end else begin
      e.region = RGN_MISC;
      e.offset = {3'b000, addr[14:0]};
    end
    return e;
  endfunction

endpackage

// File: rtl/dl_fifo.sv
// Synchronous first-word-fall-through FIFO for routed download bytes.
module dl_fifo
  import joust2_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = ENTRY_W
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/joust2_dl_router.sv
// Routes HPS ROM download bytes to the williams2 ROM regions through a stall FIFO,
// tracking byte count, additive checksum and completion.
module joust2_dl_router
  import joust2_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned INDEX = 0
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [15:0] ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        rom_valid,
  input  logic        rom_ready,
  output logic [1:0]  rom_region,
  output logic [17:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic [18:0] byte_count,
  output logic [7:0]  checksum,
  output logic        addr_overflow,
  output logic        load_done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] WAIT_LEVEL = (AW+1)'(DEPTH - 1);

  dl_state_t  state;
  dl_state_t  state_nxt;
  logic       dl_prev;
  logic       index_hit;
  logic       wr_hit;
  logic       in_range;
  logic       push_blocked;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [AW:0] fifo_count;
  logic       start;
  rom_entry_t wr_entry;
  rom_entry_t head;

  assign index_hit    = (ioctl_index == INDEX[15:0]);
  assign wr_hit       = ioctl_wr && ioctl_download && index_hit && (state == ST_LOAD);
  assign in_range     = (ioctl_addr < ROM_LIMIT);
  assign fifo_pop     = rom_valid && rom_ready;
  assign push_blocked = fifo_full && !fifo_pop;
  assign fifo_push    = wr_hit && in_range && !push_blocked;
  assign start        = (state == ST_IDLE) && ioctl_download && !dl_prev && index_hit;
  assign wr_entry     = decode_entry(ioctl_addr, ioctl_dout);

  dl_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (wr_entry),
    .pop     (fifo_pop),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Head is masked while empty so the outputs read zero instead of stale RAM.
  assign rom_valid  = !fifo_empty;
  assign rom_region = fifo_empty ? '0 : head.region;
  assign rom_addr   = fifo_empty ? '0 : head.offset;
  assign rom_data   = fifo_empty ? '0 : head.data;
  assign ioctl_wait = (fifo_count >= WAIT_LEVEL) || (state == ST_DRAIN);
  assign load_done  = (state == ST_DONE);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      dl_prev       <= 1'b0;
      byte_count    <= '0;
      checksum      <= '0;
      addr_overflow <= 1'b0;
    end else begin
      state   <= state_nxt;
      dl_prev <= ioctl_download;
      if (start) begin
        byte_count    <= '0;
        checksum      <= '0;
        addr_overflow <= 1'b0;
      end else begin
        if (fifo_push) begin
          if (byte_count != '1) byte_count <= byte_count + 1'b1;
          checksum <= checksum + ioctl_dout;
        end
        if (wr_hit && (!in_range || push_blocked)) addr_overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_LOAD;
      ST_LOAD:  if (!ioctl_download) state_nxt = ST_DRAIN;
      // Leave on the final pop itself so load_done lands one cycle after it.
      ST_DRAIN: if (fifo_empty || ((fifo_count == (AW+1)'(1)) && fifo_pop)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_joust2_dl_router.sv
// Self-checking bench for joust2_dl_router: vector table plus queue scoreboard.
module tb_joust2_dl_router;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [15:0] ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        rom_valid;
  logic        rom_ready;
  logic [1:0]  rom_region;
  logic [17:0] rom_addr;
  logic [7:0]  rom_data;
  logic [18:0] byte_count;
  logic [7:0]  checksum;
  logic        addr_overflow;
  logic        load_done;

  always #5 clk_sys = ~clk_sys;

  joust2_dl_router #(
    .DEPTH (4),
    .INDEX (0)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .rom_valid      (rom_valid),
    .rom_ready      (rom_ready),
    .rom_region     (rom_region),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .byte_count     (byte_count),
    .checksum       (checksum),
    .addr_overflow  (addr_overflow),
    .load_done      (load_done)
  );

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic [1:0]  region;
    logic [17:0] offset;
  } vec_t;

  vec_t        vecs [4];
  logic [27:0] sb_q [$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          ld_cnt = 0;
  int          ld_cyc = -1;
  int          last_pop_cyc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [27:0] model(input logic [24:0] a, input logic [7:0] d);
    logic [24:0] off;
    logic [1:0]  r;
    if (a < 25'h20000) begin
      r = 2'd0; off = a;
    end else if (a < 25'h30000) begin
      r = 2'd1; off = a - 25'h20000;
    end else if (a < 25'h38000) begin
      r = 2'd2; off = a - 25'h30000;
    end else begin
      r = 2'd3; off = a - 25'h38000;
    end
    return {r, off[17:0], d};
  endfunction

  // One clock: observe mid-cycle with final inputs, then return just after the edge.
  task automatic step();
    @(negedge clk_sys);
    if (load_done) begin
      ld_cnt++;
      ld_cyc = cyc;
    end
    if (rom_valid && rom_ready) begin
      last_pop_cyc = cyc;
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_extra: got 0x%0h expected no byte", {rom_region, rom_addr, rom_data});
      end else begin
        chk("sb_byte", 32'({rom_region, rom_addr, rom_data}), 32'(sb_q.pop_front()));
      end
    end
    @(posedge clk_sys);
    #1;
    cyc++;
  endtask

  task automatic wr(input logic [24:0] a, input logic [7:0] d, input bit expect_push);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    if (expect_push) sb_q.push_back(model(a, d));
    step();
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl();
    ioctl_index    = 16'd0;
    ioctl_download = 1'b1;
    step();
  endtask

  task automatic wait_done(input int max_cyc);
    int start_cnt;
    start_cnt = ld_cnt;
    for (int i = 0; i < max_cyc && ld_cnt == start_cnt; i++) step();
    chk("load_done_pulse", 32'(ld_cnt - start_cnt), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ld_before;
    vecs[0] = '{addr: 25'h00005, data: 8'h11, region: 2'd0, offset: 18'h00005};
    vecs[1] = '{addr: 25'h20010, data: 8'h22, region: 2'd1, offset: 18'h00010};
    vecs[2] = '{addr: 25'h30003, data: 8'h33, region: 2'd2, offset: 18'h00003};
    vecs[3] = '{addr: 25'h38007, data: 8'h44, region: 2'd3, offset: 18'h00007};

    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = '0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; rom_ready = 1'b1;
    step(); step();
    chk("rst_wait", 32'(ioctl_wait), 32'd0);
    chk("rst_valid", 32'(rom_valid), 32'd0);
    chk("rst_rom", 32'({rom_region, rom_addr, rom_data}), 32'd0);
    chk("rst_count", 32'(byte_count), 32'd0);
    chk("rst_sum", 32'(checksum), 32'd0);
    chk("rst_ovf", 32'(addr_overflow), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    reset_n = 1'b1;
    step();

    // Region map, one cycle latency.
    start_dl();
    for (int i = 0; i < 4; i++) begin
      ioctl_addr = vecs[i].addr;
      ioctl_dout = vecs[i].data;
      ioctl_wr   = 1'b1;
      sb_q.push_back({vecs[i].region, vecs[i].offset, vecs[i].data});
      step();
      ioctl_wr = 1'b0;
      chk("lat_valid", 32'(rom_valid), 32'd1);
      chk("lat_region", 32'(rom_region), 32'(vecs[i].region));
      chk("lat_offset", 32'(rom_addr), 32'(vecs[i].offset));
      chk("lat_data", 32'(rom_data), 32'(vecs[i].data));
    end
    step();
    chk("map_count", 32'(byte_count), 32'd4);
    chk("map_sum", 32'(checksum), 32'hAA);

    // Out-of-range byte is dropped.
    wr(25'h40000, 8'hAA, 1'b0);
    chk("ovf_flag", 32'(addr_overflow), 32'd1);
    chk("ovf_valid", 32'(rom_valid), 32'd0);
    chk("ovf_count", 32'(byte_count), 32'd4);
    chk("ovf_sum", 32'(checksum), 32'hAA);

    ioctl_index = 16'd1;
    wr(25'h00001, 8'h55, 1'b0);
    ioctl_index = 16'd0;
    chk("idx_valid", 32'(rom_valid), 32'd0);
    chk("idx_count", 32'(byte_count), 32'd4);

    ioctl_download = 1'b0;
    wait_done(10);
    chk("idle_wait", 32'(ioctl_wait), 32'd0);

    // Whole download under a foreign index is ignored.
    ld_before = ld_cnt;
    ioctl_index = 16'd1;
    ioctl_download = 1'b1;
    step();
    wr(25'h00000, 8'h77, 1'b0);
    step();
    chk("fidx_valid", 32'(rom_valid), 32'd0);
    chk("fidx_count", 32'(byte_count), 32'd4);
    chk("fidx_ovf", 32'(addr_overflow), 32'd1);
    ioctl_download = 1'b0;
    repeat (4) step();
    chk("fidx_done", 32'(ld_cnt), 32'(ld_before));
    ioctl_index = 16'd0;

    // 256 bytes of 0x01.
    start_dl();
    chk("clr_count", 32'(byte_count), 32'd0);
    chk("clr_sum", 32'(checksum), 32'd0);
    chk("clr_ovf", 32'(addr_overflow), 32'd0);
    for (int i = 0; i < 256; i++) begin
      ioctl_addr = 25'(i);
      ioctl_dout = 8'h01;
      ioctl_wr   = 1'b1;
      sb_q.push_back(model(25'(i), 8'h01));
      step();
    end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    wait_done(20);
    chk("bulk_count", 32'(byte_count), 32'd256);
    chk("bulk_sum", 32'(checksum), 32'd0);
    chk("bulk_sb_empty", 32'(sb_q.size()), 32'd0);

    // Back-pressure, then drain with load_done timing.
    rom_ready = 1'b0;
    start_dl();
    wr(25'h00100, 8'h00, 1'b1);
    chk("stall_wait1", 32'(ioctl_wait), 32'd0);
    wr(25'h00101, 8'h01, 1'b1);
    chk("stall_wait2", 32'(ioctl_wait), 32'd0);
    wr(25'h00102, 8'h02, 1'b1);
    chk("stall_wait3", 32'(ioctl_wait), 32'd1);
    step();
    chk("stall_hold_valid", 32'(rom_valid), 32'd1);
    chk("stall_hold_data", 32'(rom_data), 32'h00);
    rom_ready = 1'b1;
    step();
    chk("release_wait", 32'(ioctl_wait), 32'd0);
    chk("release_head", 32'(rom_data), 32'h01);
    rom_ready = 1'b0;
    ioctl_download = 1'b0;
    step();
    chk("drain_wait", 32'(ioctl_wait), 32'd1);
    rom_ready = 1'b1;
    wait_done(10);
    chk("done_latency", 32'(ld_cyc - last_pop_cyc), 32'd1);
    step();
    chk("after_done_wait", 32'(ioctl_wait), 32'd0);
    chk("stall_sb_empty", 32'(sb_q.size()), 32'd0);

    // Reset mid-download with two bytes queued.
    rom_ready = 1'b0;
    start_dl();
    wr(25'h00010, 8'hC1, 1'b1);
    wr(25'h00020, 8'hC2, 1'b1);
    chk("prerst_valid", 32'(rom_valid), 32'd1);
    ld_before = ld_cnt;
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    #1;
    chk("rst_async_valid", 32'(rom_valid), 32'd0);
    sb_q.delete();
    step(); step();
    reset_n = 1'b1;
    rom_ready = 1'b1;
    repeat (6) step();
    chk("rst_no_done", 32'(ld_cnt), 32'(ld_before));
    chk("rst_post_valid", 32'(rom_valid), 32'd0);
    chk("rst_post_count", 32'(byte_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
